// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared state encoding and sizes for the capture ring writer
package capture_pkg;

  typedef enum logic [1:0] {
    CAP_IDLE = 2'b00,
    CAP_RUN  = 2'b01,
    CAP_HDR  = 2'b10,
    CAP_STOP = 2'b11
  } cap_state_t;

  localparam int WORD_BYTES = 4;
  localparam int LEN_W      = 16;

endpackage

// File: rtl/capture_ring_ptr.sv
// rtl/capture_ring_ptr.sv - ring pointer advance by one word with wrap to zero
module capture_ring_ptr
  import capture_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] ptr,
  input  logic [N-1:0] buf_size,
  output logic [N-1:0] next_ptr
);

  logic [N-1:0] w_sum;

  assign w_sum    = ptr + N'(WORD_BYTES);
  assign next_ptr = (w_sum == buf_size) ? '0 : w_sum;

endmodule

// File: rtl/capture_writer.sv
// rtl/capture_writer.sv - stream-to-Avalon-MM ring buffer writer
// Optional per-packet length header slot: CAPTURE_WRITER_HEADER_EN.
module capture_writer
  import capture_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [N-1:0] base_addr,
  input  logic [N-1:0] buf_size,
  input  logic [N-1:0] st_data,
  input  logic         st_valid,
  output logic         st_ready,
  input  logic         st_sop,
  input  logic         st_eop,
  input  logic [1:0]   st_empty,
  output logic [N-1:0] avm_address,
  output logic         avm_write,
  output logic [N-1:0] avm_writedata,
  output logic [3:0]   avm_byteenable,
  input  logic         avm_waitrequest,
  output logic [1:0]   state,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] wr_ptr,
  output logic [N-1:0] pkt_count
);

  cap_state_t   r_state, w_state_nxt;
  logic [N-1:0] r_wr_ptr, r_pkt_count, r_addr, r_data;
  logic [3:0]   r_be;
  logic         r_avm_write, r_in_pkt, r_out_eop;
  logic         w_start, w_can_load, w_accept, w_wr_done, w_commit, w_hold_in, w_stop_ok;
  logic [N-1:0] w_slot, w_ptr_adv;
  logic [3:0]   w_be;

`ifdef CAPTURE_WRITER_HEADER_EN
  logic [N-1:0]     r_hdr_ptr, w_ptr_skip;
  logic [LEN_W-1:0] r_len, w_len_base, w_len_nxt;
  logic [LEN_W:0]   w_len_sum;
  logic             r_hdr_pend, w_hdr_load;

  // The sop word skips one slot so the header can be back-filled once the length is known.
  capture_ring_ptr #(.N(N)) u_hdr_adv (.ptr(r_wr_ptr), .buf_size(buf_size), .next_ptr(w_ptr_skip));

  assign w_slot     = st_sop ? w_ptr_skip : r_wr_ptr;
  assign w_hold_in  = r_hdr_pend;
  assign w_hdr_load = (r_state == CAP_RUN) && r_hdr_pend && w_wr_done;
  assign w_commit   = (r_state == CAP_HDR) && w_wr_done;
  assign w_len_base = st_sop ? '0 : r_len;
  assign w_len_sum  = {1'b0, w_len_base} + (LEN_W+1)'(WORD_BYTES)
                      - (st_eop ? (LEN_W+1)'(st_empty) : '0);
  assign w_len_nxt  = w_len_sum[LEN_W] ? '1 : w_len_sum[LEN_W-1:0];
`else
  assign w_slot    = r_wr_ptr;
  assign w_hold_in = 1'b0;
  assign w_commit  = (r_state == CAP_RUN) && r_out_eop && w_wr_done;
`endif

  capture_ring_ptr #(.N(N)) u_data_adv (.ptr(w_slot), .buf_size(buf_size), .next_ptr(w_ptr_adv));

  assign w_be       = st_eop ? (4'hF >> st_empty) : 4'hF;
  assign w_can_load = !r_avm_write || !avm_waitrequest;
  assign w_wr_done  = r_avm_write && !avm_waitrequest;
  assign st_ready   = (r_state == CAP_RUN) && (enable || r_in_pkt) && !w_hold_in && w_can_load;
  assign w_accept   = st_valid && st_ready;
  assign w_start    = ((r_state == CAP_IDLE) || (r_state == CAP_STOP)) && enable && (buf_size != '0);
  // Stop only between packets once the last write has left the output register.
  assign w_stop_ok  = !enable && !r_in_pkt && !w_hold_in && (!r_avm_write || w_wr_done);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= CAP_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CAP_IDLE, CAP_STOP: if (w_start) w_state_nxt = CAP_RUN;
      CAP_RUN: begin
        if (w_stop_ok) w_state_nxt = CAP_STOP;
`ifdef CAPTURE_WRITER_HEADER_EN
        if (w_hdr_load) w_state_nxt = CAP_HDR;
`endif
      end
      CAP_HDR: if (w_wr_done) w_state_nxt = enable ? CAP_RUN : CAP_STOP;
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_pkt_count <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_be        <= '0;
      r_avm_write <= 1'b0;
      r_in_pkt    <= 1'b0;
      r_out_eop   <= 1'b0;
    end else begin
      if (w_start) begin
        r_wr_ptr    <= '0;
        r_pkt_count <= '0;
        r_in_pkt    <= 1'b0;
      end
      if (w_accept) begin
        r_avm_write <= 1'b1;
        r_addr      <= base_addr + w_slot;
        r_data      <= st_data;
        r_be        <= w_be;
        r_wr_ptr    <= w_ptr_adv;
        r_in_pkt    <= (st_sop || r_in_pkt) && !st_eop;
        r_out_eop   <= st_eop;
      end
`ifdef CAPTURE_WRITER_HEADER_EN
      else if (w_hdr_load) begin
        r_avm_write <= 1'b1;
        r_addr      <= base_addr + r_hdr_ptr;
        r_data      <= {{(N-LEN_W){1'b0}}, r_len};
        r_be        <= 4'hF;
      end
`endif
      else if (w_wr_done) begin
        r_avm_write <= 1'b0;
      end
      if (w_commit) r_pkt_count <= r_pkt_count + 1'b1;
    end
  end

`ifdef CAPTURE_WRITER_HEADER_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hdr_ptr  <= '0;
      r_len      <= '0;
      r_hdr_pend <= 1'b0;
    end else begin
      if (w_start) r_hdr_pend <= 1'b0;
      if (w_accept) begin
        r_len <= w_len_nxt;
        if (st_sop) r_hdr_ptr <= r_wr_ptr;
        if (st_eop) r_hdr_pend <= 1'b1;
      end else if (w_hdr_load) begin
        r_hdr_pend <= 1'b0;
      end
    end
  end
`endif

  assign avm_address    = r_addr;
  assign avm_write      = r_avm_write;
  assign avm_writedata  = r_data;
  assign avm_byteenable = r_be;
  assign state          = r_state;
  assign busy           = (r_state == CAP_RUN) || (r_state == CAP_HDR);
  assign done           = (r_state == CAP_STOP);
  assign wr_ptr         = r_wr_ptr;
  assign pkt_count      = r_pkt_count;

endmodule

// File: tb/tb_capture_writer.sv
// tb/tb_capture_writer.sv - directed scoreboard bench for capture_writer
module tb_capture_writer;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, enable, st_valid, st_ready, st_sop, st_eop, avm_write, avm_waitrequest;
  logic        busy, done;
  logic [31:0] base_addr, buf_size, st_data, avm_address, avm_writedata, wr_ptr, pkt_count;
  logic [1:0]  st_empty, state;
  logic [3:0]  avm_byteenable;

  exp_t q[$];
  exp_t last_exp;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] exp_ptr, hdr_ptr;
  int   exp_len, exp_pkts;

  capture_writer #(.N(32)) dut (
    .clk(clk), .reset(reset), .enable(enable), .base_addr(base_addr), .buf_size(buf_size),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready), .st_sop(st_sop),
    .st_eop(st_eop), .st_empty(st_empty), .avm_address(avm_address), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .state(state), .busy(busy), .done(done),
    .wr_ptr(wr_ptr), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] adv(input logic [31:0] p);
    return (p + 32'd4 == buf_size) ? 32'd0 : p + 32'd4;
  endfunction

  function automatic logic [3:0] be_for(input logic eop, input logic [1:0] emp);
    if (!eop) return 4'hF;
    case (emp)
      2'd0:    return 4'hF;
      2'd1:    return 4'h7;
      2'd2:    return 4'h3;
      default: return 4'h1;
    endcase
  endfunction

  // Completion monitor: a write retires when avm_write is high and waitrequest is low.
  always @(negedge clk) begin
    exp_t e;
    if (reset && avm_write && !avm_waitrequest) begin
      check("write_expected", 72'(q.size() != 0), 72'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("wr_addr", 72'(avm_address), 72'(e.addr));
        check("wr_data", 72'(avm_writedata), 72'(e.data));
        check("wr_be", 72'(avm_byteenable), 72'(e.be));
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic sop, input logic eop, input logic [1:0] emp);
    exp_t e;
    int   cyc;
    logic acc;
`ifdef CAPTURE_WRITER_HEADER_EN
    if (sop) begin
      hdr_ptr = exp_ptr;
      exp_ptr = adv(exp_ptr);
    end
`endif
    if (sop) exp_len = 0;
    e.addr = base_addr + exp_ptr;
    e.data = d;
    e.be   = be_for(eop, emp);
    q.push_back(e);
    last_exp = e;
    exp_ptr  = adv(exp_ptr);
    exp_len  = exp_len + 4 - (eop ? int'(emp) : 0);
    if (eop) begin
      exp_pkts++;
`ifdef CAPTURE_WRITER_HEADER_EN
      e.addr = base_addr + hdr_ptr;
      e.data = {16'h0, 16'(exp_len)};
      e.be   = 4'hF;
      q.push_back(e);
`endif
    end
    st_data = d; st_sop = sop; st_eop = eop; st_empty = emp; st_valid = 1'b1;
    acc = 1'b0;
    cyc = 0;
    while (!acc && cyc < 50) begin
      @(negedge clk);
      acc = st_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0; st_empty = 2'd0;
    check("accept", 72'(acc), 72'd1);
    if (acc) begin
      check("latency_write", 72'(avm_write), 72'd1);
      check("latency_addr", 72'(avm_address), 72'(last_exp.addr));
    end
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while ((q.size() != 0 || avm_write) && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("drain", 72'(q.size() == 0 && !avm_write), 72'd1);
  endtask

  task automatic wait_state(input logic [1:0] s);
    int cyc = 0;
    while (state !== s && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("reach_state", 72'(state), 72'(s));
  endtask

  task automatic restart(input logic [31:0] bs);
    enable = 1'b0;
    wait_state(2'b11);
    buf_size = bs;
    enable   = 1'b1;
    @(posedge clk);
    #1;
    exp_ptr  = 0;
    exp_pkts = 0;
    check("restart_state", 72'(state), 72'd1);
    check("restart_wr_ptr", 72'(wr_ptr), 72'd0);
    check("restart_pkt_count", 72'(pkt_count), 72'd0);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; base_addr = 32'h3000_0000; buf_size = 32'd0;
    st_data = '0; st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0; st_empty = 2'd0;
    avm_waitrequest = 1'b0;
    exp_ptr = 0; hdr_ptr = 0; exp_len = 0; exp_pkts = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 72'(state), 72'd0);
    check("rst_busy", 72'(busy), 72'd0);
    check("rst_done", 72'(done), 72'd0);
    check("rst_st_ready", 72'(st_ready), 72'd0);
    check("rst_avm_write", 72'(avm_write), 72'd0);
    check("rst_avm_address", 72'(avm_address), 72'd0);
    check("rst_avm_writedata", 72'(avm_writedata), 72'd0);
    check("rst_avm_byteenable", 72'(avm_byteenable), 72'd0);
    check("rst_wr_ptr", 72'(wr_ptr), 72'd0);
    check("rst_pkt_count", 72'(pkt_count), 72'd0);

    // Zero-sized ring must not start
    reset = 1'b1; enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("bufsize0_idle", 72'(state), 72'd0);

    // Single 3-word packet, last word has one empty byte
    buf_size = 32'd64;
    @(posedge clk);
    #1;
    check("run_state", 72'(state), 72'd1);
    check("run_busy", 72'(busy), 72'd1);
    send(32'hA0A1_A2A3, 1'b1, 1'b0, 2'd0);
    send(32'hB0B1_B2B3, 1'b0, 1'b0, 2'd0);
    send(32'hC0C1_C2C3, 1'b0, 1'b1, 2'd1);
    wait_drain();
`ifdef CAPTURE_WRITER_HEADER_EN
    check("pkt1_wr_ptr", 72'(wr_ptr), 72'd16);
`else
    check("pkt1_wr_ptr", 72'(wr_ptr), 72'd12);
`endif
    check("pkt1_pkt_count", 72'(pkt_count), 72'd1);

    // Wrap in a 16-byte ring
    restart(32'd16);
    for (int i = 0; i < 6; i++)
      send(32'h1000_0000 + 32'(i), i == 0, i == 5, 2'd0);
    wait_drain();
`ifdef CAPTURE_WRITER_HEADER_EN
    check("wrap_wr_ptr", 72'(wr_ptr), 72'd12);
`else
    check("wrap_wr_ptr", 72'(wr_ptr), 72'd8);
`endif
    check("wrap_pkt_count", 72'(pkt_count), 72'd1);

    // Five-cycle stall on the second word
    send(32'h2222_0001, 1'b1, 1'b0, 2'd0);
    send(32'h2222_0002, 1'b0, 1'b0, 2'd0);
    avm_waitrequest = 1'b1;
    st_data = 32'h2222_0003; st_eop = 1'b1; st_empty = 2'd2; st_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold", {avm_address, avm_writedata, avm_byteenable, 4'(avm_write)},
            {last_exp.addr, last_exp.data, last_exp.be, 4'd1});
      check("stall_ready", 72'(st_ready), 72'd0);
      @(posedge clk);
      #1;
    end
    avm_waitrequest = 1'b0;
    st_valid = 1'b0;
    send(32'h2222_0003, 1'b0, 1'b1, 2'd2);
    wait_drain();
    check("stall_pkt_count", 72'(pkt_count), 72'(exp_pkts));

    // Enable dropped mid-packet
    send(32'h3333_0001, 1'b1, 1'b0, 2'd0);
    enable = 1'b0;
    send(32'h3333_0002, 1'b0, 1'b0, 2'd0);
    send(32'h3333_0003, 1'b0, 1'b1, 2'd3);
    wait_state(2'b11);
    check("stop_done", 72'(done), 72'd1);
    check("stop_busy", 72'(busy), 72'd0);
    check("stop_queue", 72'(q.size()), 72'd0);
    check("stop_pkt_count", 72'(pkt_count), 72'(exp_pkts));
    st_data = 32'h4444_0001; st_sop = 1'b1; st_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stopped_ready", 72'(st_ready), 72'd0);
    end
    @(posedge clk);
    #1;
    st_valid = 1'b0; st_sop = 1'b0;

    // Reset during a stalled write
    enable = 1'b1;
    @(posedge clk);
    #1;
    exp_ptr = 0;
    avm_waitrequest = 1'b1;
    send(32'h5555_0001, 1'b1, 1'b0, 2'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_write", 72'(avm_write), 72'd0);
    check("rst_mid_state", 72'(state), 72'd0);
    check("rst_mid_wr_ptr", 72'(wr_ptr), 72'd0);
    q.delete();
    avm_waitrequest = 1'b0;
    enable = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/capture_writer.md
# capture_writer

Avalon-MM write master that moves captured packet words from the capture stream into the SDRAM ring buffer configured through `register_bank`. It sits between the packet-capture stream and the HPS SDRAM bridge, consuming `out_write_address` (base) and the control bits, and returning `state`, `busy` and `done` for the control register. Words are written sequentially with wrap-around. Optionally, each packet is preceded by a length header word.

## Interface
- `N`, 32: data, address and pointer width; must be 32.
- `clk` in 1: single clock.
- `reset` in 1: synchronous reset, active-low.
- `enable` in 1: run request, control register bit 2.
- `base_addr` in N: ring buffer byte base address, word-aligned.
- `buf_size` in N: ring size in bytes; must be a multiple of 4 and ≥ 8.
- `st_data` in N: capture word, byte 0 in bits [7:0].
- `st_valid` in 1 / `st_ready` out 1: stream handshake.
- `st_sop` in 1 / `st_eop` in 1: first and last word of a packet.
- `st_empty` in 2: invalid trailing bytes in the eop word.
- `avm_address` out N, `avm_write` out 1, `avm_writedata` out N, `avm_byteenable` out 4: Avalon-MM write master signals.
- `avm_waitrequest` in 1: slave stall.
- `state` out 2, `busy` out 1, `done` out 1: status for the control register.
- `wr_ptr` out N: byte offset of the next free slot.
- `pkt_count` out N: number of packets fully committed.

## Operation
- States (`state` encoding):
  - `IDLE`=00: after reset.
  - `RUN`=01.
  - `HDR`=10: writing the header.
  - `STOP`=11: done.
- `IDLE`/`STOP` → `RUN` when `enable`=1 and `buf_size`≠0. Entry clears `wr_ptr`, `pkt_count` and `done`.
- `RUN`:
  - `st_ready` = `enable_latched` & (!`avm_write` | !`avm_waitrequest`).
  - An accepted word loads the one-deep output register with `avm_address`=`base_addr`+`wr_ptr`, `avm_writedata`=`st_data` and `avm_byteenable`=4'hF.
  - On the eop word, `avm_byteenable` = 4'hF >> `st_empty`.
  - `wr_ptr` advances by 4 per accepted word.
- Wrap: if `wr_ptr`+4 == `buf_size`, the next pointer is 0. Every pointer advance uses this rule.
- Packet byte length: words×4 − `st_empty`, held in a 16-bit counter that saturates at 16'hFFFF.
- After eop is accepted:
  - With `CAPTURE_WRITER_HEADER_EN` defined, go to `HDR` once the eop write completes.
  - Without it, increment `pkt_count` on eop write completion and stay in `RUN`.
- `enable` falling while in `RUN`:
  - If a packet is open, keep accepting until eop.
  - Then drain the output register (and the header write, if enabled) and go to `STOP`.
  - Words arriving between packets are not accepted once stopping.
- `busy`=1 in `RUN` and `HDR`. `done`=1 only in `STOP`.
- Overrun of unread data is not detected; the ring overwrites the oldest data.

## Timing
- Reset values:
  - `state`=`IDLE`, `busy`=0, `done`=0.
  - `st_ready`=0, `avm_write`=0, `avm_address`=0, `avm_writedata`=0, `avm_byteenable`=0.
  - `wr_ptr`=0, `pkt_count`=0.
- Latency: a stream word accepted at edge k appears with `avm_write`=1 at edge k+1.
- The output register is held stable while `avm_waitrequest`=1. A write completes at the first edge where `avm_write` & !`avm_waitrequest`.
- Throughput: 1 word per cycle with no waitrequest.
- Header overhead: at least 1 cycle per packet, with `st_ready`=0 in `HDR`.
- Accepting a new word in the same cycle the previous write completes is legal.
- Reset in mid-transfer deasserts `avm_write` at the next edge. The resulting protocol violation is accepted.

## Configuration
- `CAPTURE_WRITER_HEADER_EN` defined:
  - On sop acceptance, the current `wr_ptr` is saved as `hdr_ptr` and the pointer advances 4 (with wrap) before the data slot is addressed, so the sop word lands at `hdr_ptr`+4.
  - In `HDR`, the master writes {16'h0, length} to `base_addr`+`hdr_ptr` with byteenable 4'hF.
  - `pkt_count` increments on completion of that write, and the block returns to `RUN` or `STOP`.
- Not defined: `HDR` is unreachable, no slot is reserved, and the data layout is packed words only.

## Structure
- Package `capture_pkg` holds:
  - the `cap_state_t` enum (`CAP_IDLE`, `CAP_RUN`, `CAP_HDR`, `CAP_STOP`);
  - `WORD_BYTES`=4;
  - `LEN_W`=16.
- Sub-module `capture_ring_ptr` is combinational: (`ptr`, `buf_size`) → next pointer with wrap. It is instantiated for both data and header slot advance.

## Test plan
- `base_addr`=32'h3000_0000, `buf_size`=64, no waitrequest, a single 3-word packet with `st_empty`=1 (no header) → writes at offsets 0, 4, 8; last `avm_byteenable`=4'h7; `wr_ptr`=12; `pkt_count`=1.
- Same 3-word packet with `CAPTURE_WRITER_HEADER_EN` → data at offsets 4, 8, 12; header {16'h0, 16'd11} at offset 0; `wr_ptr`=16.
- `buf_size`=16, a 6-word packet (no header) → addresses go 0, 4, 8, 12, 0, 4; `wr_ptr`=8.
- `avm_waitrequest` held high for 5 cycles on the 2nd word → `avm_address`, `avm_writedata` and `avm_byteenable` are stable for all 5 cycles; `st_ready`=0; no word is lost.
- `enable` dropped mid-packet → the remaining words through eop are written, then `state`=11, `done`=1, `busy`=0; the next sop is not accepted.
- `reset` low during a stalled write → the next edge shows `avm_write`=0, `state`=00, `wr_ptr`=0.
